// File: rtl/rx_pkt_capture_pkg.sv
// Shared definitions for the receive packet-capture stage: capture mode codes,
// FSM state encodings and the width of one buffered entry {last, q, i}.
package rx_pkt_capture_pkg;

  typedef enum logic [1:0] {
    RX_MODE_OFF    = 2'b00,
    RX_MODE_SINGLE = 2'b01,
    RX_MODE_CONT   = 2'b10,
    RX_MODE_FREE   = 2'b11
  } rx_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_SOP    = 3'd1,
    ST_FRAME_START = 3'd2,
    ST_CAPTURE     = 3'd3,
    ST_SKIP        = 3'd4
  } rx_state_e;

  // One FIFO entry carries the last flag above the Q and I samples.
  function automatic int entry_width(input int dw);
    return 2 * dw + 1;
  endfunction

  // Where the FSM goes once a frame (stored or skipped) has run its full length.
  function automatic rx_state_e next_after_frame(input rx_mode_e mode);
    case (mode)
      RX_MODE_CONT: return ST_WAIT_SOP;
      RX_MODE_FREE: return ST_FRAME_START;
      default:      return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rx_pkt_capture_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Storage is a plain array read into a
// registered output stage; o_count reports every entry held, including the one
// sitting in the output register, so the parent can reserve space exactly.
module rx_pkt_capture_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_vld,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    mem_cnt_q;
  logic [CW-1:0]    mem_cnt_d;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;
  logic             pop;
  logic             load;

  // The output register empties on a handshake and refills from the array
  // whenever it is empty or being emptied this cycle.
  assign pop       = out_vld_q & i_rd_en;
  assign load      = (mem_cnt_q != '0) & (~out_vld_q | pop);
  assign mem_cnt_d = mem_cnt_q + CW'(i_wr_en) - CW'(load);

  // Sample storage write port.
  // NOTE: the storage array is deliberately not reset; only pointers, counts and
  // the output stage are, which keeps the array mappable onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // Pointers, fill count and the registered first-word output stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (i_wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_data_q <= mem_q[rd_ptr_q];
        out_vld_q  <= 1'b1;
      end else if (pop) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign o_rd_data = out_data_q;
  assign o_rd_vld  = out_vld_q;
  assign o_count   = mem_cnt_q + CW'(out_vld_q);

endmodule

// File: rtl/rx_pkt_capture.sv
// Packet-capture stage at the tail of the receive chain. Gates fixed-length
// frames out of the corrected I/Q stream according to the capture mode, admits
// a frame only when the FIFO can hold all of it, and presents buffered samples
// on a ready/valid stream with a last flag on the final sample of each frame.
module rx_pkt_capture
  import rx_pkt_capture_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_mode,
  input  logic          i_arm,
  input  logic [DW-1:0] i_in_i,
  input  logic [DW-1:0] i_in_q,
  input  logic          i_in_vld,
  input  logic          i_sop,
  output logic [DW-1:0] o_data_i,
  output logic [DW-1:0] o_data_q,
  output logic          o_data_vld,
  output logic          o_data_last,
  input  logic          i_data_rdy,
  output logic          o_busy,
  output logic [15:0]   o_frame_cnt,
  output logic [15:0]   o_drop_cnt
);

  localparam int EW = entry_width(DW);

  rx_mode_e                   mode;
  rx_state_e                  state_q;
  rx_state_e                  state_d;
  logic [15:0]                idx_q;
  logic [15:0]                idx_d;
  logic                       busy_q;
  logic [15:0]                frame_cnt_q;
  logic [15:0]                drop_cnt_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [EW-1:0]              rd_data;
  logic                       has_room;
  logic                       is_last;
  logic                       wr_en;
  logic                       wr_last;
  logic                       refused;
  logic                       frame_done;

  assign mode = rx_mode_e'(i_mode);

  // Admission looks only at the registered occupancy; a read in the same cycle
  // is not credited, which keeps the decision simple and conservative.
  assign has_room = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(FRAME_LEN);
  assign is_last  = (idx_q == 16'(FRAME_LEN - 1));
  assign wr_last  = (state_q == ST_CAPTURE) & is_last;

  // Next-state, index and write-strobe decode; the write happens in the same
  // cycle the sample is valid so stored data never lags the input stream.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    wr_en      = 1'b0;
    refused    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((mode == RX_MODE_SINGLE && i_arm) || mode == RX_MODE_CONT) begin
          state_d = ST_WAIT_SOP;
        end else if (mode == RX_MODE_FREE) begin
          state_d = ST_FRAME_START;
        end
      end
      ST_WAIT_SOP, ST_FRAME_START: begin
        if (mode == RX_MODE_OFF) begin
          state_d = ST_IDLE;
        end else if (i_in_vld && (i_sop || state_q == ST_FRAME_START)) begin
          if (has_room) begin
            wr_en   = 1'b1;
            state_d = ST_CAPTURE;
            idx_d   = 16'd1;
          end else begin
            refused = 1'b1;
            // A refused sop frame keeps waiting; free-run must skip a frame's
            // worth of samples to stay on its frame grid.
            if (state_q == ST_FRAME_START) begin
              state_d = ST_SKIP;
              idx_d   = 16'd1;
            end
          end
        end
      end
      ST_CAPTURE, ST_SKIP: begin
        if (i_in_vld) begin
          wr_en = (state_q == ST_CAPTURE);
          if (is_last) begin
            state_d    = next_after_frame(mode);
            idx_d      = '0;
            frame_done = (state_q == ST_CAPTURE);
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, sample index, registered busy flag and statistics counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == ST_WAIT_SOP) || (state_d == ST_CAPTURE);
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (refused && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  rx_pkt_capture_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_data ({wr_last, i_in_q, i_in_i}),
    .i_rd_en   (i_data_rdy),
    .o_rd_data (rd_data),
    .o_rd_vld  (o_data_vld),
    .o_count   (fifo_count)
  );

  assign o_data_i    = rd_data[DW-1:0];
  assign o_data_q    = rd_data[2*DW-1:DW];
  assign o_data_last = rd_data[2*DW];
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule
